nand_op_sequencer: RTL and testbench
====================================

Name: nand_op_sequencer

Overview:
- Sequenced logic unit that computes NAND, AND, OR or XOR of two WIDTH-bit operands using exactly one shared combinational NAND cell.
- Evaluates one NAND per clock and keeps intermediate results in local registers.
- Sits between a requesting control block and the shared NAND datapath.
- Provides a start/busy/done handshake and a registered result.

Parameters:
- WIDTH, 4, operand and result bit width (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when idle.
- op  input  2  operation: 0 NAND, 1 AND, 2 OR, 3 XOR.
- in_data1  input  WIDTH  operand A.
- in_data2  input  WIDTH  operand B.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle completion pulse.
- out_data  output  WIDTH  registered result; holds until the next completion.

Behaviour:
- Reset (async assert, rst_n low): state=IDLE, step=0, busy=0, done=0, out_data=0, operand/temp registers=0.
- Reset mid-operation aborts the operation. No done pulse is produced.
- IDLE: on an edge with start=1, latch op, in_data1, in_data2; go to RUN; step=0; busy=1. With start=0, stay in IDLE.
- RUN: each edge performs one NAND step, selected by op and step, through the single NAND cell.
  - NAND, N=1: r=~(A&B).
  - AND, N=2: t=~(A&B); r=~(t&t).
  - OR, N=3: t=~(A&A); u=~(B&B); r=~(t&u).
  - XOR, N=4: t=~(A&B); u=~(A&t); v=~(B&t); r=~(u&v).
- Cell operand mux: combinational from op/step and the latched operand/temp registers. Step results go into temp registers t, u, v.
- On step N-1's edge:
  - out_data<=r, done<=1, busy<=0, state=IDLE.
  - Latency: N edges after the accepting edge. Results are ready 1/2/3/4 cycles after start for NAND/AND/OR/XOR.
- done is high for exactly one cycle, then returns to 0.
- start while busy=1 is ignored and not queued. Inputs changing during RUN have no effect; operands were latched at acceptance.
- Back-to-back operation: start held high during the done cycle is accepted on that edge, since the state is already IDLE. Throughput is one op per N+1 cycles.
- All arithmetic is bitwise with no carries. Widths stay WIDTH throughout. step is a 2-bit counter that never wraps past N-1 for the active op.
- out_data changes only on a completion edge or on reset.

Decomposition:
- Shared package holds:
  - op encodings: OP_NAND=0, OP_AND=1, OP_OR=2, OP_XOR=3.
  - per-op step count constants (1, 2, 3, 4).
  - the state enum IDLE/RUN.
- One sub-module: the existing combinational NAND cell nand_2_9, instantiated once with WIDTH passed through. Its ports are out_data, in_data1, in_data2.
- All sequencing lives in nand_op_sequencer.

Test Plan (WIDTH=4):
- Single ops, one per op (A=4'hC, B=4'hA): start with op=0 -> done exactly 1 cycle later, out_data=4'h7. op=1 -> done at cycle 2, 4'h8. op=2 -> done at cycle 3, 4'hE. op=3 -> done at cycle 4, 4'h6. busy is high from the accepting edge until the done edge in each case.
- Start while busy: XOR start, then start=1 with op=0, A=4'hF, B=4'hF on the next 3 cycles -> only one done pulse, out_data=4'h6, no second op launched.
- Operand change during RUN: OR with A=4'h3, B=4'h5; inputs switched to 4'hF/4'hF on the next cycle -> out_data=4'h7.
- Reset mid-operation: rst_n low during XOR step 2 -> immediately busy=0, done=0, out_data=0. After release, NAND of 4'hF/4'hF -> 4'h0 with done after 1 cycle.
- Back-to-back: start held high with op=1, A=4'hE, B=4'h7 -> done pulses every 3 cycles, out_data=4'h6 each time, done never high two consecutive cycles.
- Exhaustive sweep: all op × A × B (1024 cases) compared against the bitwise reference expression. The error counter must be 0 at the end.

Source files
------------

// File: rtl/nand_op_sequencer_pkg.sv
// Shared encodings for the NAND-only logic sequencer: op codes, per-op step counts, FSM states.
package nand_op_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_NAND = 2'd0,
        OP_AND  = 2'd1,
        OP_OR   = 2'd2,
        OP_XOR  = 2'd3
    } op_e;

    localparam logic [2:0] STEPS_NAND = 3'd1;
    localparam logic [2:0] STEPS_AND  = 3'd2;
    localparam logic [2:0] STEPS_OR   = 3'd3;
    localparam logic [2:0] STEPS_XOR  = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [2:0] op_steps(input op_e op);
        case (op)
            OP_NAND: op_steps = STEPS_NAND;
            OP_AND:  op_steps = STEPS_AND;
            OP_OR:   op_steps = STEPS_OR;
            default: op_steps = STEPS_XOR;
        endcase
    endfunction

endpackage

// File: rtl/nand_op_sequencer_nand_2_9.sv
// Shared combinational WIDTH-bit NAND cell.
// Latency 0 (pure combinational); no flow control.
module nand_2_9 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    output logic [WIDTH-1:0] out_data
);

    assign out_data = ~(in_data1 & in_data2);

endmodule

// File: rtl/nand_op_sequencer.sv
// NAND/AND/OR/XOR built from one NAND cell evaluated once per clock; result 1/2/3/4 cycles after start.
// start is sampled only when idle; requests while busy are dropped, not queued.
module nand_op_sequencer
    import nand_op_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_data
);

    state_e           state, state_next;
    logic [1:0]       step;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, t_q, u_q, v_q;
    logic [WIDTH-1:0] cell_x, cell_y, cell_r;
    logic             last_step;

    nand_2_9 #(.WIDTH(WIDTH)) u_nand (
        .in_data1 (cell_x),
        .in_data2 (cell_y),
        .out_data (cell_r)
    );

    // Cell operand selection: each op is a fixed NAND network unrolled over steps.
    always_comb begin
        cell_x = a_q;
        cell_y = b_q;
        case (op_q)
            OP_AND: begin
                if (step == 2'd1) begin
                    cell_x = t_q;
                    cell_y = t_q;
                end
            end
            OP_OR: begin
                case (step)
                    2'd0: cell_y = a_q;
                    2'd1: begin
                        cell_x = b_q;
                        cell_y = b_q;
                    end
                    default: begin
                        cell_x = t_q;
                        cell_y = u_q;
                    end
                endcase
            end
            OP_XOR: begin
                case (step)
                    2'd0: cell_y = b_q;
                    2'd1: cell_y = t_q;
                    2'd2: begin
                        cell_x = b_q;
                        cell_y = t_q;
                    end
                    default: begin
                        cell_x = u_q;
                        cell_y = v_q;
                    end
                endcase
            end
            default: begin
                cell_x = a_q;
                cell_y = b_q;
            end
        endcase
    end

    assign last_step = ({1'b0, step} == (op_steps(op_q) - 3'd1));
    assign busy      = (state == RUN);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step     <= 2'd0;
            op_q     <= OP_NAND;
            a_q      <= '0;
            b_q      <= '0;
            t_q      <= '0;
            u_q      <= '0;
            v_q      <= '0;
            done     <= 1'b0;
            out_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op_e'(op);
                        a_q  <= in_data1;
                        b_q  <= in_data2;
                        step <= 2'd0;
                    end
                end
                RUN: begin
                    if (last_step) begin
                        out_data <= cell_r;
                        done     <= 1'b1;
                        step     <= 2'd0;
                    end else begin
                        step <= step + 2'd1;
                        case (step)
                            2'd0:    t_q <= cell_r;
                            2'd1:    u_q <= cell_r;
                            default: v_q <= cell_r;
                        endcase
                    end
                end
                default: step <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Randomized and directed checks of nand_op_sequencer against a bitwise reference model.
module tb_nand_op_sequencer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_data;

    int vectors;
    int errors;

    nand_op_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .busy     (busy),
        .done     (done),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        case (o)
            2'd0:    ref_result = ~(a & b);
            2'd1:    ref_result = a & b;
            2'd2:    ref_result = a | b;
            default: ref_result = a ^ b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o);
        ref_latency = int'(o) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op from idle and check latency, busy, result and pulse width.
    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input string name);
        int cyc;
        logic [WIDTH-1:0] exp;
        exp = ref_result(o, a, b);
        start = 1'b1; op = o; in_data1 = a; in_data2 = b;
        tick();
        start = 1'b0; op = $urandom; in_data1 = $urandom; in_data2 = $urandom;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end
        cyc = 0;
        while (cyc < 10) begin
            tick();
            cyc++;
            if (done === 1'b1) break;
        end
        vectors++;
        if (cyc !== ref_latency(o) || done !== 1'b1) begin
            errors++;
            $display("FAIL %s latency op=%0d a=%h b=%h: got %0d want %0d", name, o, a, b, cyc, ref_latency(o));
        end
        vectors++;
        if (out_data !== exp || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s result op=%0d a=%h b=%h: got %h busy=%b want %h busy=0",
                     name, o, a, b, out_data, busy, exp);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || out_data !== exp) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b out=%h want done=0 out=%h", name, done, out_data, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'd0; in_data1 = '0; in_data2 = '0;
        repeat (3) tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b out=%h want 0/0/0", busy, done, out_data);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_single_ops();
        for (int o = 0; o < 4; o++) run_op(2'(o), 4'hC, 4'hA, "single");
    endtask

    task automatic test_start_while_busy();
        int dones;
        dones = 0;
        start = 1'b1; op = 2'd3; in_data1 = 4'hC; in_data2 = 4'hA;
        tick();
        op = 2'd0; in_data1 = 4'hF; in_data2 = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 1 || out_data !== 4'h6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy: got dones=%0d out=%h busy=%b want 1/6/0", dones, out_data, busy);
        end
    endtask

    task automatic test_operand_change();
        int cyc;
        start = 1'b1; op = 2'd2; in_data1 = 4'h3; in_data2 = 4'h5;
        tick();
        start = 1'b0; in_data1 = 4'hF; in_data2 = 4'hF; op = 2'd0;
        cyc = 0;
        while (cyc < 10 && done !== 1'b1) begin
            tick();
            cyc++;
        end
        vectors++;
        if (out_data !== 4'h7 || cyc !== 3) begin
            errors++;
            $display("FAIL operand_change: got out=%h cyc=%0d want 7 cyc=3", out_data, cyc);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        start = 1'b1; op = 2'd3; in_data1 = 4'hC; in_data2 = 4'hA;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: got busy=%b done=%b out=%h want 0/0/0", busy, done, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort_no_done: got done=%b busy=%b want 0/0", done, busy);
            end
        end
        run_op(2'd0, 4'hF, 4'hF, "after_reset");
    endtask

    // With start held, a new op is accepted on every done edge: period N+1.
    task automatic test_back_to_back();
        int period;
        int cyc;
        period = ref_latency(2'd1) + 1;
        start = 1'b1; op = 2'd1; in_data1 = 4'hE; in_data2 = 4'h7;
        tick();
        for (int k = 1; k <= 12; k++) begin
            tick();
            vectors++;
            if (done !== (k % period == period - 1)) begin
                errors++;
                $display("FAIL back_to_back_done k=%0d: got %b want %b", k, done, (k % period == period - 1));
            end
            if (done === 1'b1) begin
                vectors++;
                if (out_data !== 4'h6) begin
                    errors++;
                    $display("FAIL back_to_back_data k=%0d: got %h want 6", k, out_data);
                end
            end
        end
        start = 1'b0;
        cyc = 0;
        while (cyc < 10 && !(busy === 1'b0 && done === 1'b0)) begin
            tick();
            cyc++;
        end
        vectors++;
        if (busy !== 1'b0 || out_data !== 4'h6) begin
            errors++;
            $display("FAIL back_to_back_drain: got busy=%b out=%h want 0/6", busy, out_data);
        end
    endtask

    task automatic test_sweep();
        for (int o = 0; o < 4; o++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run_op(2'(o), 4'(a), 4'(b), "sweep");
    endtask

    // Random ops separated by random idle gaps; result must hold while idle.
    task automatic test_random();
        logic [1:0]       o;
        logic [WIDTH-1:0] a, b, exp;
        int gap;
        for (int n = 0; n < 100; n++) begin
            o = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
            exp = ref_result(o, a, b);
            run_op(o, a, b, "random");
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                vectors++;
                if (out_data !== exp || done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL random_hold: got out=%h done=%b busy=%b want %h/0/0", out_data, done, busy, exp);
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single_ops();
        test_start_while_busy();
        test_operand_change();
        test_reset_mid_op();
        test_back_to_back();
        test_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
